// File: rtl/load_return_unit.sv
// Load return unit: issues a word-aligned read, waits for the memory acknowledge,
// then extracts and sign/zero-extends the addressed big-endian byte or halfword.
module load_return_unit #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] addr,
  input  logic [2:0]  load_type,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        busy,
  output logic        valid,
  output logic [31:0] o,
  output logic        addr_err,
  output logic        tmo_err
);

  typedef enum logic [1:0] {StIdle, StReq, StDone} state_e;

  localparam logic [CNT_W-1:0] CntLast = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [1:0]       off_q;
  logic [2:0]       type_q;
  logic [CNT_W-1:0] cnt;
  logic             legal;
  logic [15:0]      sel_half;
  logic [7:0]       sel_byte;
  logic [31:0]      ext;

  always_comb begin
    legal = 1'b0;
    unique case (load_type)
      3'd0:       legal = (addr[1:0] == 2'b00);
      3'd1, 3'd2: legal = ~addr[0];
      3'd3, 3'd4: legal = 1'b1;
      default:    legal = 1'b0;
    endcase
  end

  // Big-endian lanes: offset 0 is the most significant byte of the word.
  always_comb begin
    sel_half = off_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    sel_byte = 8'h00;
    unique case (off_q)
      2'd0: sel_byte = mem_rdata[31:24];
      2'd1: sel_byte = mem_rdata[23:16];
      2'd2: sel_byte = mem_rdata[15:8];
      2'd3: sel_byte = mem_rdata[7:0];
      default: sel_byte = 8'h00;
    endcase
    ext = mem_rdata;
    unique case (type_q)
      3'd1:    ext = {{16{sel_half[15]}}, sel_half};
      3'd2:    ext = {16'h0000, sel_half};
      3'd3:    ext = {{24{sel_byte[7]}}, sel_byte};
      3'd4:    ext = {24'h000000, sel_byte};
      default: ext = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= StIdle;
      off_q    <= 2'b00;
      type_q   <= 3'd0;
      cnt      <= '0;
      mem_req  <= 1'b0;
      mem_addr <= 32'h0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      o        <= 32'h0;
      addr_err <= 1'b0;
      tmo_err  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      addr_err <= 1'b0;
      tmo_err  <= 1'b0;
      unique case (state)
        StIdle: begin
          if (start) begin
            if (legal) begin
              off_q    <= addr[1:0];
              type_q   <= load_type;
              mem_addr <= {addr[31:2], 2'b00};
              mem_req  <= 1'b1;
              busy     <= 1'b1;
              cnt      <= '0;
              state    <= StReq;
            end else begin
              addr_err <= 1'b1;
            end
          end
        end
        StReq: begin
          // An acknowledge in the final allowed cycle still wins over the timeout.
          if (mem_ack) begin
            o       <= ext;
            mem_req <= 1'b0;
            valid   <= 1'b1;
            state   <= StDone;
          end else if (cnt == CntLast) begin
            mem_req <= 1'b0;
            tmo_err <= 1'b1;
            busy    <= 1'b0;
            state   <= StIdle;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        StDone: begin
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_load_return_unit.sv
// Bench for load_return_unit: directed vector table, multi-cycle corner sequences and
// randomized loads checked against an arithmetic reference model.
module tb_load_return_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] addr;
  logic [2:0]  load_type;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        busy;
  logic        valid;
  logic [31:0] o;
  logic        addr_err;
  logic        tmo_err;

  int total = 0;
  int bad = 0;
  logic [31:0] last_o;

  typedef struct {
    logic [2:0]  lt;
    logic [31:0] a;
    logic [31:0] rd;
    int          dly;
    logic        err;
    logic [31:0] o;
  } vec_t;

  vec_t vt[14];

  load_return_unit #(.TIMEOUT(16), .CNT_W(5)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .addr      (addr),
    .load_type (load_type),
    .mem_req   (mem_req),
    .mem_addr  (mem_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .valid     (valid),
    .o         (o),
    .addr_err  (addr_err),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // Reference: pick the byte/half by shifting the word, extend with plain arithmetic.
  function automatic void model(input logic [2:0] lt, input logic [31:0] a,
                                input logic [31:0] rd, output logic err,
                                output logic [31:0] res);
    int idx;
    logic [31:0] b, h;
    idx = int'(a[1:0]);
    err = 1'b0;
    res = 32'h0;
    b = (rd >> (8 * (3 - idx))) & 32'hFF;
    case (lt)
      3'd0: if (idx != 0) err = 1'b1; else res = rd;
      3'd1, 3'd2: begin
        if (idx % 2 != 0) err = 1'b1;
        else begin
          h = (rd >> (8 * (2 - idx))) & 32'hFFFF;
          res = (lt == 3'd1 && h >= 32'd32768) ? h + 32'hFFFF0000 : h;
        end
      end
      3'd3, 3'd4: res = (lt == 3'd3 && b >= 32'd128) ? b + 32'hFFFFFF00 : b;
      default: err = 1'b1;
    endcase
  endfunction

  task automatic run_load(input logic [2:0] lt, input logic [31:0] a, input logic [31:0] rd,
                          input int dly, input logic exp_err, input logic [31:0] exp_o,
                          input logic inject, input string nm);
    @(negedge clk);
    start = 1'b1;
    addr = a;
    load_type = lt;
    @(negedge clk);
    start = 1'b0;
    if (exp_err) begin
      chk({nm, " addr_err"}, 32'(addr_err), 32'd1);
      chk({nm, " err mem_req"}, 32'(mem_req), 32'd0);
      chk({nm, " err busy"}, 32'(busy), 32'd0);
      chk({nm, " err valid"}, 32'(valid), 32'd0);
      chk({nm, " err o kept"}, o, last_o);
      @(negedge clk);
      chk({nm, " addr_err pulse"}, 32'(addr_err), 32'd0);
      return;
    end
    chk({nm, " busy"}, 32'(busy), 32'd1);
    chk({nm, " no addr_err"}, 32'(addr_err), 32'd0);
    for (int i = 0; i <= dly; i++) begin
      chk({nm, " mem_req held"}, 32'(mem_req), 32'd1);
      chk({nm, " mem_addr"}, mem_addr, {a[31:2], 2'b00});
      chk({nm, " no valid early"}, 32'(valid), 32'd0);
      mem_ack = (i == dly);
      mem_rdata = (i == dly) ? rd : $urandom;
      start = inject && (i != dly);
      addr = $urandom;
      load_type = 3'($urandom_range(0, 7));
      @(negedge clk);
    end
    mem_ack = 1'b0;
    start = 1'b0;
    chk({nm, " valid"}, 32'(valid), 32'd1);
    chk({nm, " o"}, o, exp_o);
    chk({nm, " mem_req drop"}, 32'(mem_req), 32'd0);
    chk({nm, " busy in done"}, 32'(busy), 32'd1);
    chk({nm, " no errs"}, 32'({addr_err, tmo_err}), 32'd0);
    @(negedge clk);
    chk({nm, " valid pulse"}, 32'(valid), 32'd0);
    chk({nm, " busy clear"}, 32'(busy), 32'd0);
    last_o = exp_o;
  endtask

  initial begin
    int n;
    logic m_err;
    logic [31:0] m_o, ra, rr;
    logic [2:0] rl;

    vt[0]  = '{3'd3, 32'h103, 32'h123456F0, 0, 1'b0, 32'hFFFFFFF0};
    vt[1]  = '{3'd4, 32'h103, 32'h123456F0, 0, 1'b0, 32'h000000F0};
    vt[2]  = '{3'd2, 32'h102, 32'hABCD8001, 1, 1'b0, 32'h00008001};
    vt[3]  = '{3'd1, 32'h100, 32'hABCD8001, 0, 1'b0, 32'hFFFFABCD};
    vt[4]  = '{3'd0, 32'h200, 32'hDEADBEEF, 5, 1'b0, 32'hDEADBEEF};
    vt[5]  = '{3'd1, 32'h101, 32'h0, 0, 1'b1, 32'h0};
    vt[6]  = '{3'd0, 32'h102, 32'h0, 0, 1'b1, 32'h0};
    vt[7]  = '{3'd6, 32'h100, 32'h0, 0, 1'b1, 32'h0};
    vt[8]  = '{3'd3, 32'h100, 32'h80000000, 2, 1'b0, 32'hFFFFFF80};
    vt[9]  = '{3'd3, 32'h101, 32'h00800000, 0, 1'b0, 32'hFFFFFF80};
    vt[10] = '{3'd1, 32'h102, 32'h00007FFF, 3, 1'b0, 32'h00007FFF};
    vt[11] = '{3'd4, 32'h102, 32'h0000A500, 0, 1'b0, 32'h000000A5};
    vt[12] = '{3'd2, 32'h103, 32'h0, 0, 1'b1, 32'h0};
    vt[13] = '{3'd5, 32'h000, 32'h0, 0, 1'b1, 32'h0};

    reset = 1'b1;
    start = 1'b0;
    addr = 32'h0;
    load_type = 3'd0;
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    last_o = 32'h0;
    repeat (2) @(negedge clk);
    chk("reset outputs", {25'h0, mem_req, busy, valid, addr_err, tmo_err, 2'b00}, 32'h0);
    chk("reset mem_addr", mem_addr, 32'h0);
    chk("reset o", o, 32'h0);
    reset = 1'b0;

    // Stray acknowledge while idle must not produce a result.
    @(negedge clk);
    mem_ack = 1'b1;
    mem_rdata = 32'h55555555;
    @(negedge clk);
    mem_ack = 1'b0;
    chk("idle ack ignored", {30'h0, valid, busy}, 32'h0);

    for (int i = 0; i < 14; i++)
      run_load(vt[i].lt, vt[i].a, vt[i].rd, vt[i].dly, vt[i].err, vt[i].o, (i == 4),
               $sformatf("vec%0d", i));

    // Timeout: no acknowledge ever arrives.
    @(negedge clk);
    start = 1'b1;
    addr = 32'h300;
    load_type = 3'd0;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (mem_req && n < 40) begin
      n++;
      @(negedge clk);
    end
    chk("tmo req cycles", 32'(n), 32'd16);
    chk("tmo_err", 32'(tmo_err), 32'd1);
    chk("tmo valid/busy", {30'h0, valid, busy}, 32'h0);
    chk("tmo o kept", o, last_o);
    @(negedge clk);
    chk("tmo pulse", 32'(tmo_err), 32'd0);
    run_load(3'd0, 32'h304, 32'hCAFEF00D, 1, 1'b0, 32'hCAFEF00D, 1'b0, "after tmo");

    // Asynchronous reset in the middle of a request.
    @(negedge clk);
    start = 1'b1;
    addr = 32'h400;
    load_type = 3'd0;
    @(negedge clk);
    start = 1'b0;
    chk("pre-reset mem_req", 32'(mem_req), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset mem_req/busy", {30'h0, mem_req, busy}, 32'h0);
    @(negedge clk);
    chk("reset no pulses", {29'h0, valid, addr_err, tmo_err}, 32'h0);
    reset = 1'b0;
    last_o = 32'h0;
    run_load(3'd4, 32'h001, 32'h00FF0000, 0, 1'b0, 32'h000000FF, 1'b0, "post reset");

    for (int i = 0; i < 40; i++) begin
      rl = 3'($urandom_range(0, 7));
      ra = $urandom;
      rr = $urandom;
      model(rl, ra, rr, m_err, m_o);
      run_load(rl, ra, rr, $urandom_range(0, 4), m_err, m_o, 1'b1, $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule

// File: doc/load_return_unit.md
Name: load_return_unit

Overview:
- Load-side counterpart of the SB/SH store-mask path.
- Accepts a load request (LW/LH/LHU/LB/LBU) from the MEM stage and issues a word-aligned read to data memory.
- Waits for a variable-latency acknowledge, then extracts the addressed byte or halfword and sign- or zero-extends it to 32 bits.
- Returns the result with a one-cycle VALID pulse; flags misaligned or illegal requests and memory timeouts.

Parameters:
TIMEOUT, 16, max cycles in REQ without MEM_ACK before TMO_ERR (must be >= 1)
CNT_W, 5, width of the timeout counter (must hold TIMEOUT)

Ports:
CLK  input  1  system clock, rising edge
RESET  input  1  asynchronous, active-high reset
START  input  1  load request strobe, sampled in IDLE only
ADDR  input  32  byte address of the load
LOAD_TYPE  input  3  0=LW, 1=LH, 2=LHU, 3=LB, 4=LBU, 5-7 illegal
MEM_REQ  output  1  read request to data memory
MEM_ADDR  output  32  word-aligned read address
MEM_ACK  input  1  memory read data valid
MEM_RDATA  input  32  memory read word
BUSY  output  1  unit not in IDLE
VALID  output  1  one-cycle pulse; O holds the result
O  output  32  extended load result
ADDR_ERR  output  1  one-cycle pulse: misaligned address or illegal LOAD_TYPE
TMO_ERR  output  1  one-cycle pulse: memory timeout

Behaviour:
- One clock domain. RESET is asynchronous and active-high. All outputs are registered.
- Reset values: state IDLE; MEM_REQ, BUSY, VALID, ADDR_ERR and TMO_ERR all 0; MEM_ADDR = 0; O = 0; counter = 0.
- Memory byte order is big-endian:
  - offset 0 -> RDATA[31:24], offset 3 -> RDATA[7:0].
  - halfword offset 0 -> RDATA[31:16], offset 2 -> RDATA[15:0].
- States: IDLE, REQ, DONE.
- IDLE, START=0: no action.
- IDLE, START=1, request legal: latch ADDR[1:0] and LOAD_TYPE; MEM_ADDR <= {ADDR[31:2],2'b00}; MEM_REQ <= 1; BUSY <= 1; counter <= 0; go to REQ.
- IDLE, START=1, request not legal (any of the following): ADDR_ERR pulses 1 cycle, no MEM_REQ, stay IDLE, O unchanged.
  - LOAD_TYPE in 5-7.
  - LW with ADDR[1:0] != 0.
  - LH/LHU with ADDR[0] = 1.
- REQ:
  - MEM_REQ and MEM_ADDR held stable until MEM_ACK.
  - MEM_ACK=1 (may arrive in the first REQ cycle): capture the extended result into O; MEM_REQ <= 0; go to DONE.
  - MEM_ACK=0: counter increments. When counter reaches TIMEOUT-1 with no ack: MEM_REQ <= 0, TMO_ERR pulses, BUSY <= 0, go to IDLE, O unchanged.
  - MEM_ACK outside REQ is ignored.
- Extension rules:
  - LW: O = RDATA.
  - LH: sign-extend the selected half. LHU: zero-extend it.
  - LB: sign-extend the selected byte. LBU: zero-extend it.
- DONE: VALID = 1 for exactly this cycle; BUSY <= 0; go to IDLE. O holds its value until the next successful load.
- START while BUSY=1 is ignored (no queueing). A new START in the cycle after DONE is accepted.
- Latency: START in cycle n -> MEM_REQ high in n+1. MEM_ACK in cycle n+1+k -> VALID in n+2+k. Minimum START-to-VALID is 2 cycles.
- RESET asserted mid-operation aborts immediately: MEM_REQ drops asynchronously, there is no VALID or error pulse, and the state returns to IDLE.
- VALID, ADDR_ERR and TMO_ERR are mutually exclusive in every cycle.

Test Plan:
1. LB at ADDR=0x103, RDATA=0x123456F0, ack on first REQ cycle -> MEM_ADDR=0x100, VALID 2 cycles after START, O=0xFFFFFFF0.
2. LBU at the same address and data -> O=0x000000F0. LHU at ADDR=0x102, RDATA=0xABCD8001 -> O=0x00008001. LH at ADDR=0x100, same data -> O=0xFFFFABCD.
3. LW at ADDR=0x200, ack delayed 5 cycles, RDATA=0xDEADBEEF -> MEM_REQ high 6 cycles, MEM_ADDR stable, VALID on the 7th cycle after REQ start, O=0xDEADBEEF. START pulses while BUSY are ignored.
4. Error requests each produce a one-cycle ADDR_ERR pulse, MEM_REQ=0, BUSY=0:
   - LH at ADDR=0x101.
   - LW at ADDR=0x102.
   - LOAD_TYPE=6 at ADDR=0x100.
5. LW with MEM_ACK never asserted, TIMEOUT=16 -> TMO_ERR pulses once after 16 REQ cycles, MEM_REQ drops, no VALID, O retains its previous value. The next START is accepted normally.
6. RESET asserted asynchronously mid-REQ -> MEM_REQ and BUSY go to 0 immediately with no VALID. After RESET releases, an LBU at 0x001 with RDATA=0x00FF0000 returns O=0x000000FF.
